// File: rtl/adv7513_i2c_arbiter_if.sv
// adv7513_i2c_arbiter_if: requester-side and i2c_master-side signals of the arbiter.
// slave modport is the arbiter's view; master modport is the requesters/i2c_master view.
interface adv7513_i2c_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  // Requester side
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [7*NUM_REQ-1:0] req_chip;
  logic [8*NUM_REQ-1:0] req_reg;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rdata;
  logic                 err;
  logic                 timeout;

  // i2c_master side
  logic [6:0]           m_chip_addr;
  logic [7:0]           m_reg_addr;
  logic [7:0]           m_data_in;
  logic                 m_write_en;
  logic                 m_read_en;
  logic                 m_busy;
  logic [2:0]           m_status;
  logic [7:0]           m_data_out;

  modport slave (
    input  req, req_rw, req_chip, req_reg, req_wdata,
    input  m_busy, m_status, m_data_out,
    output gnt, done, rdata, err, timeout,
    output m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
  );

  modport master (
    output req, req_rw, req_chip, req_reg, req_wdata,
    output m_busy, m_status, m_data_out,
    input  gnt, done, rdata, err, timeout,
    input  m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
  );
endinterface

// File: rtl/adv7513_i2c_arbiter.sv
// adv7513_i2c_arbiter: round-robin sharing of one i2c_master between NUM_REQ requesters,
// one single-byte register transaction per grant.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module adv7513_i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  adv7513_i2c_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               rw_q, rw_d;
  logic [6:0]         chip_q, chip_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               wen_q, wen_d;
  logic               ren_q, ren_d;

`ifdef ARB_TIMEOUT_EN
  logic [31:0]        cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               tmo_q, tmo_d;
`endif

  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW-1:0]    cand;
  logic               wait_first;

  // The requester finishing this cycle is masked so it cannot be re-granted back to back
  assign eligible = bus.req & ~done_q;

  // The enable pulse is still high in the first WAIT cycle; busy is not valid yet then
  assign wait_first = wen_q | ren_q;

  // Round-robin search starting one past the last served requester
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((32'(last_q) + off) % NUM_REQ);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    last_d  = last_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    chip_d  = chip_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          idx_d           = pick_idx;
          rw_d            = bus.req_rw[pick_idx];
          chip_d          = bus.req_chip[32'(pick_idx) * 7 +: 7];
          reg_d           = bus.req_reg[32'(pick_idx) * 8 +: 8];
          wdata_d         = bus.req_wdata[32'(pick_idx) * 8 +: 8];
          state_d         = StIssue;
        end
      end
      StIssue: begin
        ren_d   = rw_q;
        wen_d   = ~rw_q;
        state_d = StWait;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
        pend_d  = 1'b0;
`endif
      end
      StWait: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
        if (!wait_first && !bus.m_busy) begin
          rdata_d = rw_q ? bus.m_data_out : 8'h00;
          err_d   = (bus.m_status != 3'b000);
          state_d = StDone;
        end
`ifdef ARB_TIMEOUT_EN
        // Leave WAIT one cycle early so done lands TIMEOUT_CYCLES cycles after WAIT entry
        else if (cnt_q + 32'd2 >= TIMEOUT_CYCLES) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          pend_d  = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        last_d  = idx_q;
        state_d = StIdle;
`ifdef ARB_TIMEOUT_EN
        tmo_d   = pend_q;
        pend_d  = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      idx_q   <= '0;
      rw_q    <= 1'b0;
      chip_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      chip_q  <= chip_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.m_chip_addr = chip_q;
  assign bus.m_reg_addr  = reg_q;
  assign bus.m_data_in   = wdata_q;
  assign bus.m_write_en  = wen_q;
  assign bus.m_read_en   = ren_q;

`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = tmo_q;
`else
  assign bus.timeout = 1'b0;
  // Watchdog length is meaningless without the watchdog
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: doc/adv7513_i2c_arbiter.md
Name: adv7513_i2c_arbiter

Overview:
Shares one i2c_master instance between NUM_REQ requesters, e.g. the ADV7513 init sequencer and the register read/debug block. Round-robin arbitration grants one requester a single one-byte register transaction at a time. The block drives the master's command inputs, waits for completion, and returns read data and error status to the granted requester.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 1000000, WAIT-state cycle limit before forced abort (only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester transaction request, level
req_rw  in  NUM_REQ  1 = read, 0 = write
req_chip  in  7*NUM_REQ  7-bit chip address per requester, packed, requester i at [7i+6:7i]
req_reg  in  8*NUM_REQ  register address per requester, packed
req_wdata  in  8*NUM_REQ  write data per requester, packed
gnt  out  NUM_REQ  one-hot grant, high for the whole transaction
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  out  8  read data, valid while any done bit is high
err  out  1  transaction error, valid while any done bit is high
timeout  out  1  one-cycle pulse on watchdog abort
m_chip_addr  out  7  to i2c_master chip_addr
m_reg_addr  out  8  to i2c_master reg_addr
m_data_in  out  8  to i2c_master data_in
m_write_en  out  1  to i2c_master write_en, one-cycle pulse
m_read_en  out  1  to i2c_master read_en, one-cycle pulse
m_busy  in  1  from i2c_master busy
m_status  in  3  from i2c_master status; nonzero = error
m_data_out  in  8  from i2c_master data_out

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE; gnt, done, rdata, err, timeout, m_* outputs all 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts immediately. No done is issued. The i2c_master shares the same reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - eligible = req & ~done. A requester whose done is high this cycle is masked.
  - If eligible is nonzero, pick the first set bit searching last+1, last+2, ... with wrap-around.
  - Register gnt (one-hot). Latch that requester's rw, chip, reg and wdata into m_chip_addr, m_reg_addr, m_data_in and an internal rw flag. Go to ISSUE.
  - Operands are latched once; later changes on req_* are ignored.
- ISSUE (exactly 1 cycle):
  - m_read_en<=rw, m_write_en<=~rw. Go to WAIT.
  - m_*_en is high during the first WAIT cycle.
- WAIT:
  - m_write_en<=0, m_read_en<=0.
  - On the first WAIT cycle (enable still high) ignore m_busy; this covers the master's one-cycle busy latency.
  - Afterwards, when m_busy==0: rdata<=m_data_out (read) or 8'h00 (write); err<=(m_status!=0). Go to DONE.
- DONE (1 cycle):
  - done<=gnt; gnt<=0; last<=index of the granted requester. Go to IDLE.
  - done is therefore high in the following IDLE cycle with gnt already low.
- Latency: req rising in IDLE at cycle t -> gnt at t+1, m_*_en at t+2, done at least 5 cycles after t (plus I2C busy time).
- A requester dropping req while granted: the transaction still completes and done still pulses.
- Simultaneous requests: round-robin strictly alternates. No requester waits more than NUM_REQ-1 transactions.
- A requester must drop req (or present new operands) in its done cycle; masking guarantees at least one cycle of re-arbitration.
- gnt is never multi-hot and is never high outside ISSUE/WAIT/DONE.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES with m_busy still high, go to DONE with err=1, rdata=8'h00, and timeout pulsed 1 cycle together with done.
  - The counter clears on entering WAIT.
- Undefined: no counter; timeout is tied 0; WAIT waits indefinitely.

Test Plan:
- Single read: req[0]=1, rw=1, chip=7'h39, reg=8'h00; model busy for 20 cycles, data_out=8'h13, status=0 -> one m_read_en pulse with m_reg_addr=8'h00; done[0] one cycle; rdata=8'h13; err=0.
- Single write: req[1]=1, rw=0, reg=8'h41, wdata=8'h10 -> one m_write_en pulse with m_data_in=8'h10; done[1] pulse; err=0.
- Contention: req=2'b11 held, 4 transactions -> grant order 0,1,0,1; gnt always one-hot; each done pulse matches the prior grant.
- NACK: model status=3'b001 -> done pulse with err=1.
- Reset mid-WAIT: reset low during busy -> next cycle all outputs 0, no done; after release, req[1] alone is granted normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50): busy stuck high -> done pulse with err=1 and timeout=1, 50 cycles after entering WAIT.
